// File: rtl/mandel_pkg.sv
// Shared types and default geometry for the Mandelbrot pixel pipeline.
// Used by the scheduler, colour LUT and stream packer.
package mandel_pkg;

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'b00,
        SLOT_BUSY = 2'b01,
        SLOT_DONE = 2'b10
    } slot_state_t;

    typedef enum logic {
        F_IDLE = 1'b0,
        F_RUN  = 1'b1
    } frame_state_t;

    localparam int DEF_NUM_ENGINES = 4;
    localparam int DEF_WIDTH       = 640;
    localparam int DEF_HEIGHT      = 480;
    localparam int DEF_ITER_W      = 16;
    localparam int DEF_X_W         = 10;
    localparam int DEF_Y_W         = 10;

endpackage

// File: rtl/pixel_scheduler_slot.sv
// One in-flight pixel slot: lifecycle state, captured result and
// framing tags for the engine it shadows.
module sched_slot
    import mandel_pkg::*;
#(
    parameter int ITER_W = DEF_ITER_W
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              set_busy,
    input  logic              set_sof,
    input  logic              set_eol,
    input  logic              done,
    input  logic [ITER_W-1:0] done_iter,
    input  logic              retire,
    output slot_state_t       state,
    output logic [ITER_W-1:0] iter,
    output logic              sof,
    output logic              eol
);

    // Results arriving for a slot that is not BUSY are dropped.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= SLOT_IDLE;
            iter  <= '0;
            sof   <= 1'b0;
            eol   <= 1'b0;
        end else if (retire) begin
            state <= SLOT_IDLE;
        end else if (set_busy) begin
            state <= SLOT_BUSY;
            sof   <= set_sof;
            eol   <= set_eol;
        end else if (done && state == SLOT_BUSY) begin
            state <= SLOT_DONE;
            iter  <= done_iter;
        end
    end

endmodule

// File: rtl/pixel_scheduler.sv
// Round-robin pixel issue to the engine pool with in-order,
// raster-ordered retirement and sof/eol framing.
module pixel_scheduler
    import mandel_pkg::*;
#(
    parameter int NUM_ENGINES = DEF_NUM_ENGINES,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HEIGHT      = DEF_HEIGHT,
    parameter int ITER_W      = DEF_ITER_W,
    parameter int X_W         = DEF_X_W,
    parameter int Y_W         = DEF_Y_W
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          frame_start,
    input  logic                          enable,
    output logic                          busy,
    output logic                          frame_done,
    output logic [NUM_ENGINES-1:0]        eng_start,
    output logic [X_W-1:0]                eng_x,
    output logic [Y_W-1:0]                eng_y,
    input  logic [NUM_ENGINES-1:0]        eng_done,
    input  logic [NUM_ENGINES*ITER_W-1:0] eng_iter,
    output logic [ITER_W-1:0]             pix_iter,
    output logic                          pix_valid,
    output logic                          pix_sof,
    output logic                          pix_eol,
    input  logic                          pix_ready
);

    localparam int PW = $clog2(NUM_ENGINES);

    frame_state_t state, state_nxt;

    logic [PW-1:0]  issue_ptr;
    logic [PW-1:0]  retire_ptr;
    logic [X_W-1:0] x_cnt;
    logic [Y_W-1:0] y_cnt;
    logic           issued_all;

    slot_state_t       slot_st   [NUM_ENGINES];
    logic [ITER_W-1:0] slot_iter [NUM_ENGINES];
    logic [NUM_ENGINES-1:0] slot_sof;
    logic [NUM_ENGINES-1:0] slot_eol;
    logic [NUM_ENGINES-1:0] set_busy;
    logic [NUM_ENGINES-1:0] retire_sel;

    logic start;
    logic issue;
    logic fire;
    logic last_x;
    logic last_y;
    logic first_px;
    logic others_idle;
    logic last_retire;

    assign start    = state == F_IDLE && frame_start;
    assign issue    = state == F_RUN && enable && !issued_all
                   && slot_st[issue_ptr] == SLOT_IDLE;
    assign fire     = pix_valid && pix_ready;
    assign last_x   = x_cnt == X_W'(WIDTH - 1);
    assign last_y   = y_cnt == Y_W'(HEIGHT - 1);
    assign first_px = x_cnt == '0 && y_cnt == '0;

    assign set_busy   = issue ? NUM_ENGINES'(1) << issue_ptr : '0;
    assign retire_sel = fire ? NUM_ENGINES'(1) << retire_ptr : '0;

    // Frame ends when the only slot still in use is the one retiring.
    always_comb begin
        others_idle = 1'b1;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            if (PW'(k) != retire_ptr && slot_st[k] != SLOT_IDLE)
                others_idle = 1'b0;
        end
    end

    assign last_retire = state == F_RUN && fire
                      && issued_all && others_idle;

    assign busy      = state == F_RUN;
    assign pix_valid = slot_st[retire_ptr] == SLOT_DONE;
    assign pix_iter  = pix_valid ? slot_iter[retire_ptr] : '0;
    assign pix_sof   = pix_valid && slot_sof[retire_ptr];
    assign pix_eol   = pix_valid && slot_eol[retire_ptr];

    always_ff @(posedge aclk) begin
        if (!aresetn) state <= F_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            F_IDLE: if (frame_start) state_nxt = F_RUN;
            F_RUN:  if (last_retire) state_nxt = F_IDLE;
            default: state_nxt = F_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            issue_ptr  <= '0;
            retire_ptr <= '0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            issued_all <= 1'b0;
            frame_done <= 1'b0;
            eng_start  <= '0;
            eng_x      <= '0;
            eng_y      <= '0;
        end else begin
            frame_done <= last_retire;
            eng_start  <= set_busy;
            if (fire) retire_ptr <= retire_ptr + 1'b1;
            if (start) begin
                issue_ptr  <= '0;
                retire_ptr <= '0;
                x_cnt      <= '0;
                y_cnt      <= '0;
                issued_all <= 1'b0;
            end else if (issue) begin
                eng_x     <= x_cnt;
                eng_y     <= y_cnt;
                issue_ptr <= issue_ptr + 1'b1;
                if (last_x) begin
                    x_cnt <= '0;
                    if (last_y) issued_all <= 1'b1;
                    else        y_cnt <= y_cnt + 1'b1;
                end else begin
                    x_cnt <= x_cnt + 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_ENGINES; k++) begin : g_slot
        sched_slot #(
            .ITER_W(ITER_W)
        ) u_slot (
            .aclk      (aclk),
            .aresetn   (aresetn),
            .set_busy  (set_busy[k]),
            .set_sof   (first_px),
            .set_eol   (last_x),
            .done      (eng_done[k]),
            .done_iter (eng_iter[k*ITER_W +: ITER_W]),
            .retire    (retire_sel[k]),
            .state     (slot_st[k]),
            .iter      (slot_iter[k]),
            .sof       (slot_sof[k]),
            .eol       (slot_eol[k])
        );
    end

endmodule

// File: tb/tb_pixel_scheduler.sv
// Frame-level bench for pixel_scheduler: modelled engines plus a
// raster-order reference for issue and retire streams.
module tb_pixel_scheduler;

    localparam int NE = 4;
    localparam int W  = 8;
    localparam int H  = 2;
    localparam int IW = 16;
    localparam int NP = W * H;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          frame_start;
    logic          enable;
    logic          busy;
    logic          frame_done;
    logic [NE-1:0] eng_start;
    logic [9:0]    eng_x;
    logic [9:0]    eng_y;
    logic [NE-1:0] eng_done;
    logic [NE*IW-1:0] eng_iter;
    logic [IW-1:0] pix_iter;
    logic          pix_valid;
    logic          pix_sof;
    logic          pix_eol;
    logic          pix_ready;

    pixel_scheduler #(
        .NUM_ENGINES(NE), .WIDTH(W), .HEIGHT(H),
        .ITER_W(IW), .X_W(10), .Y_W(10)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .frame_start(frame_start), .enable(enable),
        .busy(busy), .frame_done(frame_done),
        .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
        .eng_done(eng_done), .eng_iter(eng_iter),
        .pix_iter(pix_iter), .pix_valid(pix_valid),
        .pix_sof(pix_sof), .pix_eol(pix_eol),
        .pix_ready(pix_ready)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int lat_mode;
        int rdy_mode;
        int pause_at;
        bit disturb;
        int exp_pix;
        int exp_fd;
    } row_t;

    int total = 0;
    int bad = 0;

    int issue_cnt, out_cnt, step_idx, last_hs, fd_cnt;
    int eng_cnt [NE];
    int eng_res [NE];
    bit owned   [NE];
    int lat_mode, rdy_mode, pause_at, pause_left, rdy_phase;
    bit disturb, pause_done, en_prev;
    bit prev_v, prev_r, prev_s, prev_e;
    logic [IW-1:0] prev_it;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int lat_of(int k);
        if (lat_mode == 0) return 3;
        if (lat_mode == 1) return (k == 0) ? 9 : 2;
        return $urandom_range(1, 8);
    endfunction

    task automatic model_clear();
        issue_cnt = 0; out_cnt = 0; fd_cnt = 0;
        last_hs = -10; step_idx = 0;
        for (int k = 0; k < NE; k++) begin
            eng_cnt[k] = 0; owned[k] = 0; eng_res[k] = 0;
        end
        pause_left = 0; pause_done = 0; rdy_phase = 0;
        en_prev = 1; prev_v = 0; prev_r = 1;
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
        step_idx++;
        frame_start = 1'b0;
        eng_done = '0;
        for (int k = 0; k < NE; k++) begin
            if (eng_cnt[k] > 0) begin
                eng_cnt[k]--;
                if (eng_cnt[k] == 0) begin
                    eng_done[k] = 1'b1;
                    eng_iter[k*IW +: IW] = IW'(eng_res[k]);
                end
            end
        end
        if (!en_prev) chk("pause_no_start", 32'(eng_start), 0);
        if (eng_start != '0) begin
            chk("start_onehot", 32'($onehot(eng_start)), 1);
            chk("start_engine", 32'(eng_start), 1 << (issue_cnt % NE));
            chk("start_x", 32'(eng_x), issue_cnt % W);
            chk("start_y", 32'(eng_y), issue_cnt / W);
            for (int k = 0; k < NE; k++) begin
                if (eng_start[k]) begin
                    chk("start_slot_free", 32'(owned[k]), 0);
                    owned[k] = 1;
                    eng_cnt[k] = lat_of(k);
                    eng_res[k] = int'(eng_x) + W * int'(eng_y);
                end
            end
            issue_cnt++;
        end
        if (disturb) begin
            if (busy && $urandom_range(0, 9) == 0) frame_start = 1'b1;
            if ($urandom_range(0, 5) == 0) begin
                int k;
                k = $urandom_range(0, NE - 1);
                if (!owned[k] && eng_cnt[k] == 0 && !eng_done[k]) begin
                    eng_done[k] = 1'b1;
                    eng_iter[k*IW +: IW] = 16'hdead;
                end
            end
        end
        if (pause_at >= 0 && !pause_done && issue_cnt == pause_at) begin
            pause_left = 20;
            pause_done = 1;
        end
        if (pause_left > 0) begin
            enable = 1'b0;
            pause_left--;
        end else begin
            enable = (rdy_mode == 2) ? ($urandom_range(0, 9) != 0) : 1'b1;
        end
        en_prev = enable;
        if (frame_done) begin
            fd_cnt++;
            chk("fd_timing", 32'(step_idx), 32'(last_hs + 1));
            chk("fd_pixels", 32'(out_cnt), NP);
            chk("fd_busy", 32'(busy), 0);
        end
        if (prev_v && !prev_r) begin
            chk("hold_valid", 32'(pix_valid), 1);
            chk("hold_iter", 32'(pix_iter), 32'(prev_it));
            chk("hold_sof", 32'(pix_sof), 32'(prev_s));
            chk("hold_eol", 32'(pix_eol), 32'(prev_e));
        end
        case (rdy_mode)
            0:       pix_ready = 1'b1;
            1:       pix_ready = (rdy_phase % 4 == 0) || (rdy_phase % 4 == 3);
            default: pix_ready = $urandom_range(0, 1) == 1;
        endcase
        rdy_phase++;
        if (pix_valid && pix_ready) begin
            chk("pix_iter", 32'(pix_iter), out_cnt);
            chk("pix_sof", 32'(pix_sof), 32'(out_cnt == 0));
            chk("pix_eol", 32'(pix_eol), 32'(out_cnt % W == W - 1));
            owned[out_cnt % NE] = 0;
            out_cnt++;
            last_hs = step_idx;
        end
        prev_v = pix_valid; prev_r = pix_ready;
        prev_it = pix_iter; prev_s = pix_sof; prev_e = pix_eol;
    endtask

    task automatic run_row(row_t r);
        int n;
        lat_mode = r.lat_mode;
        rdy_mode = r.rdy_mode;
        pause_at = r.pause_at;
        disturb  = r.disturb;
        model_clear();
        chk("idle_before_start", 32'(busy), 0);
        frame_start = 1'b1;
        enable = 1'b1;
        step();
        chk("busy_after_start", 32'(busy), 1);
        n = 0;
        while (fd_cnt == 0 && n < 600) begin
            step();
            n++;
        end
        chk("frame_timeout", 32'(fd_cnt != 0), 1);
        repeat (4) step();
        chk("row_pixels", 32'(out_cnt), 32'(r.exp_pix));
        chk("row_issues", 32'(issue_cnt), NP);
        chk("row_frame_done", 32'(fd_cnt), 32'(r.exp_fd));
        chk("row_busy_end", 32'(busy), 0);
    endtask

    row_t rows [7];

    initial begin
        rows[0] = '{0, 0, -1, 0, NP, 1};
        rows[1] = '{1, 0, -1, 0, NP, 1};
        rows[2] = '{0, 1, -1, 0, NP, 1};
        rows[3] = '{0, 0,  5, 0, NP, 1};
        rows[4] = '{0, 0, -1, 1, NP, 1};
        rows[5] = '{2, 2, -1, 1, NP, 1};
        rows[6] = '{2, 1,  7, 1, NP, 1};

        aresetn = 1'b0; frame_start = 1'b0; enable = 1'b1;
        eng_done = '0; eng_iter = '0; pix_ready = 1'b1;
        disturb = 0; lat_mode = 0; rdy_mode = 0; pause_at = -1;
        model_clear();
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(eng_start), 0);
        chk("rst_valid", 32'(pix_valid), 0);
        aresetn = 1'b1;

        for (int i = 0; i < 7; i++) run_row(rows[i]);

        // Reset in the middle of a frame, then stale results.
        lat_mode = 0; rdy_mode = 0; pause_at = -1; disturb = 0;
        model_clear();
        frame_start = 1'b1;
        step();
        repeat (7) step();
        aresetn = 1'b0;
        eng_done = '0;
        @(posedge aclk);
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_fd", 32'(frame_done), 0);
        chk("mid_rst_start", 32'(eng_start), 0);
        chk("mid_rst_x", 32'(eng_x), 0);
        chk("mid_rst_y", 32'(eng_y), 0);
        chk("mid_rst_valid", 32'(pix_valid), 0);
        chk("mid_rst_iter", 32'(pix_iter), 0);
        chk("mid_rst_sof", 32'(pix_sof), 0);
        chk("mid_rst_eol", 32'(pix_eol), 0);
        aresetn = 1'b1;
        eng_done = '1;
        eng_iter = {NE{16'hbeef}};
        @(posedge aclk);
        #1;
        eng_done = '0;
        @(posedge aclk);
        #1;
        chk("stale_valid", 32'(pix_valid), 0);
        chk("stale_busy", 32'(busy), 0);
        run_row(rows[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
